mac_accum: RTL

MAC_ACCUM -- requirements
Module: mac_accum

---
 rtl/mac_accum_pkg.sv | 12 +
 rtl/mac_accum_sat_add.sv | 30 +++
 rtl/mac_accum.sv | 106 ++++++++++
 3 files changed

// File: rtl/mac_accum_pkg.sv
// Shared defaults for the multiply-accumulate block: operand/accumulator widths,
// group length and the default-width accumulator clamp limits.
package mac_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_GROUP  = 3;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage

// File: rtl/mac_accum_sat_add.sv
// Signed saturating adder: clamps the sum to the representable ACC_W range and
// flags when clamping happened.
module sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic signed [ACC_W-1:0] i_a,
    input  logic signed [ACC_W-1:0] i_b,
    output logic signed [ACC_W-1:0] o_sum,
    output logic                    o_sat
);

    localparam logic signed [ACC_W-1:0] W_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] W_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_wide;

    assign w_wide = {i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b};

    // Overflow shows as disagreement between the guard bit and the result sign.
    always_comb begin
        o_sat = w_wide[ACC_W] ^ w_wide[ACC_W-1];
        o_sum = w_wide[ACC_W-1:0];
        if (o_sat) begin
            o_sum = w_wide[ACC_W] ? W_MIN : W_MAX;
        end
    end

endmodule

// File: rtl/mac_accum.sv
// Two-stage signed multiply-accumulate: registered product, then a saturating
// group accumulator that reports each finished group when the next one loads.
module mac_accum
    import mac_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int GROUP  = DEF_GROUP
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adder_bypass,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     out_valid,
    output logic                     out_sat,
    output logic                     len_err
);

    localparam int P_W   = 2 * DATA_W;
    localparam int CNT_W = $clog2(GROUP + 2);
    localparam logic [CNT_W-1:0] CNT_GRP = CNT_W'(GROUP);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GROUP + 1);

    logic signed [P_W-1:0]   r_p;
    logic                    r_byp;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_sat_flag;
    logic [CNT_W-1:0]        r_term_cnt;
    logic                    r_started;
    logic signed [ACC_W-1:0] r_acc_out;
    logic                    r_out_valid;
    logic                    r_out_sat;
    logic                    r_len_err;

    logic signed [P_W-1:0]   w_a_ext;
    logic signed [P_W-1:0]   w_b_ext;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_sat;

    // Operands widened first so the low P_W bits of the product are exact.
    assign w_a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    assign w_b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    assign w_ext   = {{(ACC_W-P_W){r_p[P_W-1]}}, r_p};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p   <= '0;
            r_byp <= 1'b0;
        end else begin
            r_p   <= w_a_ext * w_b_ext;
            r_byp <= adder_bypass;
        end
    end

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .i_a   (r_acc),
        .i_b   (w_ext),
        .o_sum (w_sum),
        .o_sat (w_sat)
    );

    // A load both closes the previous group (report) and opens the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc       <= '0;
            r_sat_flag  <= 1'b0;
            r_term_cnt  <= '0;
            r_started   <= 1'b0;
            r_acc_out   <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_byp) begin
                if (r_started) begin
                    r_acc_out   <= r_acc;
                    r_out_sat   <= r_sat_flag;
                    r_len_err   <= (r_term_cnt != CNT_GRP);
                    r_out_valid <= 1'b1;
                end
                r_acc      <= w_ext;
                r_sat_flag <= 1'b0;
                r_term_cnt <= CNT_W'(1);
                r_started  <= 1'b1;
            end else if (r_started) begin
                r_acc      <= w_sum;
                r_sat_flag <= r_sat_flag | w_sat;
                if (r_term_cnt != CNT_MAX) begin
                    r_term_cnt <= r_term_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign acc_out   = r_acc_out;
    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;
    assign len_err   = r_len_err;

endmodule
